// File: rtl/restoring_divider.sv
// Unsigned 16-bit by 8-bit restoring divider.
// One quotient bit is resolved per clock, MSB first, so every operation takes
// exactly 16 cycles after it is accepted, whatever the operand values.
// Results sit in dedicated output registers that update only at completion.
// Iteration values never appear on the outputs.
module restoring_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    // Index of the final iteration (counter runs 0..15 while calculating).
    localparam logic [4:0] LAST_ITER = 5'd15;

    // Control and datapath state
    state_e      state_q;
    logic [4:0]  cnt_q;     // iterations already completed
    logic [8:0]  prem_q;    // partial remainder
    logic [15:0] work_q;    // dividend bits still to consume, quotient bits shifted in behind them
    logic [7:0]  dvs_q;     // divisor latched at accept

    // Registered results
    logic        done_q;
    logic [15:0] quot_q;
    logic [7:0]  rem_q;
    logic        dbz_q;

    // Next-iteration values
    logic [8:0]  shifted_d;
    logic        fits_d;
    logic [8:0]  prem_d;
    logic [15:0] work_d;

    // Between iterations the partial remainder is below the divisor, so its
    // top bit is always zero and only the low eight bits shift upward.
    logic        unused_prem_msb;
    assign unused_prem_msb = prem_q[8];

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves one unassigned,
        // which would otherwise infer a latch.
        shifted_d = {prem_q[7:0], work_q[15]};
        fits_d    = 1'b0;
        prem_d    = shifted_d;
        if (shifted_d >= {1'b0, dvs_q}) begin
            fits_d = 1'b1;
            prem_d = shifted_d - {1'b0, dvs_q};
        end
        work_d = {work_q[14:0], fits_d};
    end

    // Sequencer: accept in IDLE, iterate 16 times in CALC, publish results and pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            prem_q  <= 9'd0;
            work_q  <= 16'd0;
            dvs_q   <= 8'd0;
            done_q  <= 1'b0;
            quot_q  <= 16'd0;
            rem_q   <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples the values
            // from before the edge; blocking ones would make the outcome depend on statement order.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= dividend;
                        dvs_q   <= divisor;
                        cnt_q   <= 5'd0;
                        prem_q  <= 9'd0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        if (dvs_q == 8'd0) begin
                            // Divide by zero: saturated quotient, zero remainder, flag raised.
                            quot_q <= 16'hFFFF;
                            rem_q  <= 8'h00;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= work_d;
                            rem_q  <= prem_d[7:0];
                            dbz_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
